// File: rtl/gpio_mmio_bank.sv
// Memory-mapped GPIO bank: WIDTH pins with direction, atomic set/clear, synchronised inputs and edge interrupts.
// Optional input debouncing is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_mmio_bank #(
    parameter logic [31:0] BASE_MEMORY = 32'hFFFF_FFE0,
    parameter int          WIDTH       = 8,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0003,
    parameter int          SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int          DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      memAddress,
    input  logic [31:0]      memWriteData,
    input  logic             memWrite,
    input  logic [3:0]       byteMask,
    output logic [31:0]      memReadData,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    // Register byte k travels on bus byte 3-k in both directions.
    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] data_out_r, dir_r, irq_en_r, irq_edge_r, irq_status_r, prev_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [31:0]      rd_data_r;

    logic [WIDTH-1:0] data_out_nxt_s, dir_nxt_s, irq_en_nxt_s, irq_edge_nxt_s, status_nxt_s;
    logic [WIDTH-1:0] w1c_s, edge_s, sync_s, in_s, wbits_s, wmask_s, wsel_s;
    logic [31:0]      offset_s, wdata_sw_s, mask32_s, rd_val_s, rd_nxt_s;
    logic             hit_s, wr_s, unused_s;
    logic [2:0]       idx_s;

    assign offset_s   = memAddress - BASE_MEMORY;
    assign hit_s      = (offset_s[31:5] == 27'd0);
    assign idx_s      = memAddress[4:2];
    assign wr_s       = hit_s & memWrite;
    assign wdata_sw_s = lane_swap(memWriteData);
    assign mask32_s   = {{8{byteMask[3]}}, {8{byteMask[2]}}, {8{byteMask[1]}}, {8{byteMask[0]}}};
    assign wbits_s    = wdata_sw_s[WIDTH-1:0];
    assign wmask_s    = mask32_s[WIDTH-1:0];
    assign wsel_s     = wbits_s & wmask_s;
    assign unused_s   = ^{offset_s[4:0], wdata_sw_s, mask32_s};

    assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0]    db_cnt_r [WIDTH];
    logic [WIDTH-1:0] stable_r;

    // Per-pin debounce: adopt the synchronised value only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) db_cnt_r[i] <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] != stable_r[i]) begin
                    if (db_cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        stable_r[i] <= sync_s[i];
                        db_cnt_r[i] <= {CW{1'b0}};
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
                    end
                end else begin
                    db_cnt_r[i] <= {CW{1'b0}};
                end
            end
        end
    end

    assign in_s = stable_r;
`else
    assign in_s = sync_s;
`endif

    assign edge_s = (irq_edge_r & prev_r & ~in_s) | (~irq_edge_r & ~prev_r & in_s);

    // Register write decode; SET/CLR act on DATA_OUT, index 7 produces W1C bits.
    always_comb begin
        data_out_nxt_s = data_out_r;
        dir_nxt_s      = dir_r;
        irq_en_nxt_s   = irq_en_r;
        irq_edge_nxt_s = irq_edge_r;
        w1c_s          = {WIDTH{1'b0}};
        if (wr_s) begin
            case (idx_s)
                3'd0:    data_out_nxt_s = (data_out_r & ~wmask_s) | wsel_s;
                3'd1:    dir_nxt_s      = (dir_r & ~wmask_s) | wsel_s;
                3'd3:    data_out_nxt_s = data_out_r | wsel_s;
                3'd4:    data_out_nxt_s = data_out_r & ~wsel_s;
                3'd5:    irq_en_nxt_s   = (irq_en_r & ~wmask_s) | wsel_s;
                3'd6:    irq_edge_nxt_s = (irq_edge_r & ~wmask_s) | wsel_s;
                3'd7:    w1c_s          = wsel_s;
                default: w1c_s          = {WIDTH{1'b0}};
            endcase
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        // A fresh edge outranks a simultaneous clear.
        status_nxt_s = (irq_status_r & ~w1c_s) | edge_s;
    end

    // Read mux on pre-write register values.
    always_comb begin
        rd_val_s = 32'h0;
        case (idx_s)
            3'd0:    rd_val_s = zext(data_out_r);
            3'd1:    rd_val_s = zext(dir_r);
            3'd2:    rd_val_s = zext(in_s);
            3'd5:    rd_val_s = zext(irq_en_r);
            3'd6:    rd_val_s = zext(irq_edge_r);
            3'd7:    rd_val_s = zext(irq_status_r);
            default: rd_val_s = 32'h0;
        endcase
        if (hit_s) begin
            rd_nxt_s = lane_swap(rd_val_s);
        end else begin
            rd_nxt_s = 32'h0;
        end
    end

    // Synchroniser chain, previous-input register and all architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {WIDTH{1'b0}};
            prev_r       <= {WIDTH{1'b0}};
            data_out_r   <= OUT_RESET[WIDTH-1:0];
            dir_r        <= {WIDTH{1'b1}};
            irq_en_r     <= {WIDTH{1'b0}};
            irq_edge_r   <= {WIDTH{1'b0}};
            irq_status_r <= {WIDTH{1'b0}};
            rd_data_r    <= 32'h0;
        end else begin
            sync_r[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
            prev_r       <= in_s;
            data_out_r   <= data_out_nxt_s;
            dir_r        <= dir_nxt_s;
            irq_en_r     <= irq_en_nxt_s;
            irq_edge_r   <= irq_edge_nxt_s;
            irq_status_r <= status_nxt_s;
            rd_data_r    <= rd_nxt_s;
        end
    end

    assign memReadData = rd_data_r;
    assign gpio_out    = data_out_r;
    assign gpio_oe     = dir_r;
    assign irq         = |(irq_status_r & irq_en_r);

endmodule

// File: tb/tb_gpio_mmio_bank.sv
// Scoreboard bench for gpio_mmio_bank: directed register scenarios then random bus/pin traffic vs a bit-level model.
module tb_gpio_mmio_bank;
    localparam logic [31:0] BASE = 32'hFFFF_FFE0;
    localparam int W   = 8;
    localparam int S   = 2;
    localparam int DEB = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  memAddress, memWriteData, memReadData;
    logic         memWrite;
    logic [3:0]   byteMask;
    logic [W-1:0] gpio_in, gpio_out, gpio_oe;
    logic         irq;

    gpio_mmio_bank #(
        .BASE_MEMORY(BASE), .WIDTH(W), .OUT_RESET(32'h0000_0003), .SYNC_STAGES(S)
`ifdef GPIO_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(DEB)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .byteMask(byteMask), .memReadData(memReadData),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  rd;
        logic [W-1:0] out;
        logic [W-1:0] oe;
        logic         irq;
    } exp_t;

    exp_t sb_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state
    logic [W-1:0] out_m, dir_m, en_m, edg_m, st_m;
    logic [W-1:0] hist[$];
`ifdef GPIO_DEBOUNCE_EN
    logic [W-1:0] stab_m, pstab_m;
    logic [W-1:0] shist[$];
`endif

    function automatic logic [31:0] to_bus(input logic [W-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < W; i++) r[24 - 8*(i/8) + (i%8)] = v[i];
        return r;
    endfunction

    function automatic logic [W-1:0] bus_bits(input logic [31:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[24 - 8*(i/8) + (i%8)];
        return r;
    endfunction

    function automatic logic [W-1:0] bus_mask(input logic [3:0] bm);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = bm[i/8];
        return r;
    endfunction

    task automatic model_reset();
        out_m = 8'h03; dir_m = 8'hFF; en_m = 8'h00; edg_m = 8'h00; st_m = 8'h00;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(8'h00);
`ifdef GPIO_DEBOUNCE_EN
        stab_m = 8'h00; pstab_m = 8'h00;
        shist.delete();
`endif
    endtask

    // Advance the model across one rising edge using the inputs the bench is driving.
    task automatic model_edge();
        logic [31:0]  off, rd;
        logic [W-1:0] din, prv, syn, edge_v, wsel, msk, w1c;
        logic         hit;
        exp_t         e;
        if (!rst_n) begin
            model_reset();
            rd = 32'h0;
        end else begin
            syn = hist[hist.size() - S];
`ifdef GPIO_DEBOUNCE_EN
            din = stab_m; prv = pstab_m;
`else
            din = syn; prv = hist[hist.size() - S - 1];
`endif
            for (int i = 0; i < W; i++)
                edge_v[i] = edg_m[i] ? (prv[i] && !din[i]) : (!prv[i] && din[i]);
            off = memAddress - BASE;
            hit = (off < 32'd32);
            rd = 32'h0;
            if (hit) begin
                case (memAddress[4:2])
                    3'd0: rd = to_bus(out_m);
                    3'd1: rd = to_bus(dir_m);
                    3'd2: rd = to_bus(din);
                    3'd5: rd = to_bus(en_m);
                    3'd6: rd = to_bus(edg_m);
                    3'd7: rd = to_bus(st_m);
                    default: rd = 32'h0;
                endcase
            end
            msk  = bus_mask(byteMask);
            wsel = bus_bits(memWriteData) & msk;
            w1c  = 8'h00;
            if (hit && memWrite) begin
                case (memAddress[4:2])
                    3'd0: out_m = (out_m & ~msk) | wsel;
                    3'd1: dir_m = (dir_m & ~msk) | wsel;
                    3'd3: out_m = out_m | wsel;
                    3'd4: out_m = out_m & ~wsel;
                    3'd5: en_m  = (en_m & ~msk) | wsel;
                    3'd6: edg_m = (edg_m & ~msk) | wsel;
                    3'd7: w1c   = wsel;
                    default: w1c = 8'h00;
                endcase
            end
            st_m = (st_m & ~w1c) | edge_v;
            hist.push_back(gpio_in);
            if (hist.size() > S + 2) void'(hist.pop_front());
`ifdef GPIO_DEBOUNCE_EN
            pstab_m = stab_m;
            shist.push_back(syn);
            if (shist.size() > DEB) void'(shist.pop_front());
            if (shist.size() == DEB) begin
                for (int i = 0; i < W; i++) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    foreach (shist[j]) if (shist[j][i] == stab_m[i]) all_diff = 1'b0;
                    if (all_diff) stab_m[i] = ~stab_m[i];
                end
            end
`endif
        end
        e.rd = rd; e.out = out_m; e.oe = dir_m; e.irq = |(st_m & en_m);
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [3:0] bm, input logic [W-1:0] pins);
        memAddress = a; memWriteData = d; memWrite = we; byteMask = bm; gpio_in = pins;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] bm, input logic [W-1:0] pins);
        step(BASE + 32'(idx * 4), d, 1'b1, bm, pins);
    endtask

    task automatic rd_idle(input int idx, input logic [W-1:0] pins);
        step(BASE + 32'(idx * 4), 32'h0, 1'b0, 4'h0, pins);
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            compared++;
            if (memReadData !== e.rd) begin
                mismatched++;
                $display("FAIL rdata: got %h expected %h at %0t", memReadData, e.rd, $time);
            end
            compared++;
            if (gpio_out !== e.out) begin
                mismatched++;
                $display("FAIL gpio_out: got %h expected %h at %0t", gpio_out, e.out, $time);
            end
            compared++;
            if (gpio_oe !== e.oe) begin
                mismatched++;
                $display("FAIL gpio_oe: got %h expected %h at %0t", gpio_oe, e.oe, $time);
            end
            compared++;
            if (irq !== e.irq) begin
                mismatched++;
                $display("FAIL irq: got %b expected %b at %0t", irq, e.irq, $time);
            end
        end
    end

    initial begin
        logic [W-1:0] pins;
        logic [31:0]  r1, r2, r3, addr;
        int           sel;
        pins = 8'h00;
        rst_n = 1'b0;
        memAddress = 32'h0; memWriteData = 32'h0; memWrite = 1'b0; byteMask = 4'h0; gpio_in = 8'h00;
        model_reset();
        repeat (3) rd_idle(0, pins);
        rst_n = 1'b1;

        // Reset read-back and byte-lane writes
        rd_idle(0, pins);
        wr(0, 32'hA500_0000, 4'b0001, pins);
        wr(0, 32'h5A5A_5A5A, 4'b0010, pins);
        rd_idle(0, pins);
        rd_idle(0, pins);

        // SET / CLR
        wr(0, 32'h0F00_0000, 4'b0001, pins);
        wr(3, 32'hF000_0000, 4'b1111, pins);
        wr(4, 32'h0300_0000, 4'b1111, pins);
        wr(3, 32'hFF00_0000, 4'b0000, pins);
        rd_idle(3, pins);
        rd_idle(4, pins);
        rd_idle(0, pins);

        // Rising-edge interrupt on pin 0 (start-up edges cleared first)
        repeat (S + 2) rd_idle(7, pins);
        wr(7, 32'hFF00_0000, 4'b0001, pins);
        wr(5, 32'h0100_0000, 4'b0001, pins);
        wr(6, 32'h0000_0000, 4'b0001, pins);
        pins = 8'h01;
        repeat (S + 3) rd_idle(7, pins);
        wr(7, 32'h0100_0000, 4'b0001, pins);
        rd_idle(7, pins);

        // Falling edge on pin 1 with interrupt masked, then unmasked
        wr(6, 32'h0200_0000, 4'b0001, pins);
        wr(5, 32'h0000_0000, 4'b0001, pins);
        pins = 8'h03;
        repeat (S + 3) rd_idle(2, pins);
        pins = 8'h01;
        repeat (S + 3) rd_idle(7, pins);
        wr(5, 32'h0200_0000, 4'b0001, pins);
        rd_idle(7, pins);

        // Out-of-window reads
        step(BASE - 32'd4, 32'h0, 1'b0, 4'h0, pins);
        step(32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 4'hF, pins);

        // Edge on pin 0 coinciding with its W1C
        wr(7, 32'hFF00_0000, 4'b0001, 8'h00);
        pins = 8'h00;
        repeat (S + 2) rd_idle(7, pins);
        wr(7, 32'hFF00_0000, 4'b0001, pins);
        pins = 8'h01;
        rd_idle(7, pins);
        repeat (S - 1) rd_idle(7, pins);
        wr(7, 32'h0100_0000, 4'b0001, pins);
        rd_idle(7, pins);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            sel = int'(r1[3:0]) % 10;
            if (sel < 8) addr = BASE + 32'(sel * 4) + {30'h0, r1[5:4]};
            else if (sel == 8) addr = BASE - 32'd4;
            else addr = r3;
            if (r1[9:8] == 2'b00) pins = r3[W-1:0];
            step(addr, r2, r1[6], r1[13:10], pins);
        end

        @(negedge clk);
        #1;
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gpio_mmio_bank.md
Name: gpio_mmio_bank

Overview:
- Parametrised memory-mapped GPIO bank on the CPU data bus.
- Replaces the fixed two-LED output register with WIDTH bidirectional pins.
- Adds per-pin direction, atomic set/clear, synchronised input sampling and edge-detect interrupts with W1C status.
- Responds to a 32-byte window; the SoC ORs its read data with other MMIO slaves.

Parameters:
- BASE_MEMORY, 32'hFFFF_FFE0, first byte address of the 8-word register window.
- WIDTH, 8, number of GPIO pins; legal range 1..32.
- OUT_RESET, 32'h0000_0003, reset value of DATA_OUT[WIDTH-1:0]; default keeps active-low LEDs off.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- memAddress  in  32  byte address from the CPU.
- memWriteData  in  32  write data, big-endian lanes.
- memWrite  in  1  write strobe, valid for one cycle.
- byteMask  in  4  byte enables; bit k selects register byte k.
- memReadData  out  32  registered read data.
- gpio_in  in  WIDTH  asynchronous pad inputs.
- gpio_out  out  WIDTH  pad output values (DATA_OUT).
- gpio_oe  out  WIDTH  pad output enables (DIR; 1 = output).
- irq  out  1  level interrupt; high while |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Decode: hit = memAddress in [BASE_MEMORY, BASE_MEMORY+31]. Register index = memAddress[4:2]; memAddress[1:0] ignored.
- Lane mapping:
  - Register byte k [8k+7:8k] is written from memWriteData[31-8k:24-8k] when byteMask[k]=1.
  - Reads use the same swap in reverse.
  - Bits at or above WIDTH read 0 and ignore writes.
- Register map (index):
  - 0 DATA_OUT (RW).
  - 1 DIR (RW).
  - 2 DATA_IN (RO, synchronised pins).
  - 3 SET: W1S on DATA_OUT; reads 0.
  - 4 CLR: W1C on DATA_OUT; reads 0.
  - 5 IRQ_EN (RW).
  - 6 IRQ_EDGE (RW; 0 = rising, 1 = falling).
  - 7 IRQ_STATUS (W1C).
  - Writes to RO registers are ignored.
- Read timing: memReadData updates on the clock edge after the address is presented (1-cycle latency).
  - It returns the register value before any same-cycle write (read-before-write).
  - A non-hit cycle registers 32'h0.
- Input path:
  - gpio_in passes through a SYNC_STAGES flop chain to produce sync_in.
  - A further flop produces prev_in.
  - DATA_IN = sync_in.
- Edge detect: per pin, edge[i] = IRQ_EDGE[i] ? (prev_in[i] & ~sync_in[i]) : (~prev_in[i] & sync_in[i]).
  - Edges are detected regardless of DIR, so output loopback is visible.
- IRQ_STATUS[i]: next = (status[i] & ~w1c[i]) | edge[i].
  - A new edge in the same cycle as its W1C wins; the bit stays set.
  - Status sets even when IRQ_EN[i]=0; only irq is masked.
- SET/CLR in the same cycle cannot occur (one register per cycle).
  - A SET or CLR with byteMask=0 has no effect.
- Reset (async, rst_n low):
  - DATA_OUT = OUT_RESET.
  - DIR = all ones.
  - IRQ_EN, IRQ_EDGE, IRQ_STATUS, sync chain, prev_in and memReadData = 0.
  - irq = 0.
- After reset release, prev_in and sync_in both start at 0, so a pin held high raises a rising edge once the synchroniser fills. Firmware clears IRQ_STATUS before enabling.
- irq is combinational from registers only (no bus path), so it is glitch-free.

Optional Feature:
- GPIO_DEBOUNCE_EN defined:
  - Parameter DEBOUNCE_CYCLES (default 16) is added, plus a per-pin counter of width $clog2(DEBOUNCE_CYCLES+1).
  - sync_in feeds a stable register that updates only after the raw value differs from stable for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the stable value resets the counter.
  - DATA_IN and edge detection use the stable register.
  - Counters and stable reset to 0.
- GPIO_DEBOUNCE_EN undefined: no counters; DATA_IN = sync_in, with latency exactly SYNC_STAGES cycles to DATA_IN.

Test Plan:
- Reset: with rst_n low, gpio_out=8'h03, gpio_oe=8'hFF, irq=0. Read index 0 one cycle later gives memReadData=32'h0300_0000.
- Byte-lane write: write 32'hA500_0000 to index 0 with byteMask=4'b0001 -> gpio_out=8'hA5. With byteMask=4'b0010 -> gpio_out unchanged. Read returns 32'hA500_0000.
- SET/CLR: DATA_OUT=8'h0F. Write 32'hF000_0000 to SET -> 8'hFF. Write 32'h0300_0000 to CLR -> 8'hFC. Both reads return 0.
- Rising irq: IRQ_EN=8'h01, IRQ_EDGE=0, gpio_in[0] goes 0->1 -> IRQ_STATUS bit 0 set SYNC_STAGES+1 cycles later and irq=1. W1C 32'h0100_0000 to index 7 -> irq=0 the next cycle.
- Falling and masking: IRQ_EDGE=8'h02, IRQ_EN=0, gpio_in[1] goes 1->0 -> status bit 1 set, irq stays 0. Then setting IRQ_EN=8'h02 drives irq=1 immediately.
- Out-of-range and collision: a read at BASE_MEMORY-4 gives 32'h0. An edge on pin 0 in the same cycle as its W1C leaves status bit 0 = 1.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: a 10-cycle pulse gives no DATA_IN change. A 20-cycle pulse updates DATA_IN after 16 stable cycles.
